// File: rtl/blinky_pkg.sv
// blinky_pkg: shared mode encoding for the blinky_bank pattern generator
package blinky_pkg;
    localparam int MODE_W = 2;
    typedef logic [MODE_W-1:0] mode_t;
    localparam mode_t MODE_OFF   = 2'd0;
    localparam mode_t MODE_ON    = 2'd1;
    localparam mode_t MODE_BLINK = 2'd2;
    localparam mode_t MODE_BURST = 2'd3;
endpackage

// File: rtl/blinky_bank_if.sv
// blinky_bank_if: valid/ready config port addressing one channel per transfer
interface blinky_bank_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int BURST_W  = 8
);
    localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CH_W-1:0]    cfg_chan;
    logic [1:0]         cfg_mode;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_high;
    logic [BURST_W-1:0] cfg_count;
    modport master (output cfg_valid, cfg_chan, cfg_mode, cfg_period, cfg_high, cfg_count, input cfg_ready);
    modport slave (input cfg_valid, cfg_chan, cfg_mode, cfg_period, cfg_high, cfg_count, output cfg_ready);
endinterface

// File: rtl/blinky_chan.sv
// blinky_chan: one output channel - latched config, phase counter, burst countdown
module blinky_chan
    import blinky_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               load,
    input  mode_t              mode_in,
    input  logic [CNT_W-1:0]   period_in,
    input  logic [CNT_W-1:0]   high_in,
    input  logic [BURST_W-1:0] count_in,
    output logic               q,
    output logic               busy,
    output logic               done
);
    mode_t              mode;
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   high;
    logic [CNT_W-1:0]   phase;
    logic [BURST_W-1:0] remaining;
    logic               wrap;
    logic               pat;
    logic               burst_go;

    assign wrap     = tick && period != '0 && phase == period - 1'b1;
    assign pat      = mode == MODE_ON || (mode[1] && period != '0 && phase < high);
    assign burst_go = mode_in == MODE_BURST && count_in != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode      <= MODE_OFF;
            period    <= '0;
            high      <= '0;
            phase     <= '0;
            remaining <= '0;
            q         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            q    <= pat;
            done <= 1'b0;
            if (load) begin
                // a zero-length burst degenerates to OFF
                mode      <= (mode_in == MODE_BURST && !burst_go) ? MODE_OFF : mode_in;
                period    <= period_in;
                high      <= high_in;
                remaining <= count_in;
                phase     <= '0;
                busy      <= burst_go;
            end else if (tick) begin
                phase <= (wrap || period == '0) ? '0 : phase + 1'b1;
                if (mode == MODE_BURST && wrap) begin
                    remaining <= remaining - 1'b1;
                    if (remaining == BURST_W'(1)) begin
                        mode <= MODE_OFF;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/blinky_bank.sv
// blinky_bank: bank of independently configured LED pattern channels
// sharing one prescaler tick.
module blinky_bank
    import blinky_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int BURST_W  = 8,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                rst,
    blinky_bank_if.slave        cfg,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done
);
    localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int PS_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int BX_W = 2 ** CH_W;

    logic [PS_W-1:0]     ps;
    logic                tick;
    logic [BX_W-1:0]     busy_ext;
    logic [CHANNELS-1:0] load;

    assign tick = ps == PS_W'(PRESCALE - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ps <= '0;
        else ps <= tick ? '0 : ps + 1'b1;
    end

    // out-of-range channel numbers see a zero busy bit and are accepted harmlessly
    assign busy_ext      = BX_W'(busy);
    assign cfg.cfg_ready = !rst && !(busy_ext[cfg.cfg_chan] && cfg.cfg_mode != MODE_OFF);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign load[i] = cfg.cfg_valid && cfg.cfg_ready && cfg.cfg_chan == CH_W'(i);
        blinky_chan #(.CNT_W(CNT_W), .BURST_W(BURST_W)) u_chan (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .load      (load[i]),
            .mode_in   (cfg.cfg_mode),
            .period_in (cfg.cfg_period),
            .high_in   (cfg.cfg_high),
            .count_in  (cfg.cfg_count),
            .q         (q[i]),
            .busy      (busy[i]),
            .done      (done[i])
        );
    end
endmodule

// File: tb/tb_blinky_bank.sv
// tb_blinky_bank: directed checks of blinky_bank; main DUT has 3 channels so
// cfg_chan=CHANNELS is encodable, second DUT covers PRESCALE=3.
module tb_blinky_bank;
    import blinky_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] qa, ba, da;
    logic [3:0] qp, bp, dp;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    blinky_bank_if #(.CHANNELS(3)) cfg_a ();
    blinky_bank_if #(.CHANNELS(4)) cfg_p ();

    blinky_bank #(.CHANNELS(3), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .cfg(cfg_a), .q(qa), .busy(ba), .done(da)
    );
    blinky_bank #(.CHANNELS(4), .PRESCALE(3)) dut_p (
        .clk(clk), .rst(rst), .cfg(cfg_p), .q(qp), .busy(bp), .done(dp)
    );

    task automatic wr(input int ch, input mode_t m, input int per, input int hi, input int cnt);
        int n = 0;
        @(negedge clk);
        cfg_a.cfg_chan   = 2'(ch);
        cfg_a.cfg_mode   = m;
        cfg_a.cfg_period = 16'(per);
        cfg_a.cfg_high   = 16'(hi);
        cfg_a.cfg_count  = 8'(cnt);
        cfg_a.cfg_valid  = 1'b1;
        while (!cfg_a.cfg_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_a.cfg_ready) begin
            total++; bad++;
            $display("FAIL wr_timeout ch=%0d ready=%b required 1", ch, cfg_a.cfg_ready);
        end
        @(posedge clk);
        #1 cfg_a.cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (qa !== 3'b000) begin bad++; $display("FAIL reset_q got=%b exp=000", qa); end
        total++; if (ba !== 3'b000) begin bad++; $display("FAIL reset_busy got=%b exp=000", ba); end
        total++; if (da !== 3'b000) begin bad++; $display("FAIL reset_done got=%b exp=000", da); end
        total++; if (cfg_a.cfg_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", cfg_a.cfg_ready); end
        rst = 1'b0;
    endtask

    task automatic test_blink();
        logic e;
        wr(0, MODE_BLINK, 4, 1, 0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); @(negedge clk);
            e = (k % 4) == 0;
            total++; if (qa[0] !== e) begin bad++; $display("FAIL blink_q k=%0d got=%b exp=%b", k, qa[0], e); end
        end
        wr(0, MODE_OFF, 0, 0, 0);
    endtask

    task automatic test_burst();
        logic eq, eb, ed;
        wr(1, MODE_BURST, 3, 2, 2);
        @(negedge clk);
        total++; if (ba[1] !== 1'b1) begin bad++; $display("FAIL burst_busy_set got=%b exp=1", ba[1]); end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); @(negedge clk);
            eq = k <= 6 && (k % 3) != 0;
            eb = k < 6;
            ed = k == 6;
            total++; if (qa[1] !== eq) begin bad++; $display("FAIL burst_q k=%0d got=%b exp=%b", k, qa[1], eq); end
            total++; if (ba[1] !== eb) begin bad++; $display("FAIL burst_busy k=%0d got=%b exp=%b", k, ba[1], eb); end
            total++; if (da[1] !== ed) begin bad++; $display("FAIL burst_done k=%0d got=%b exp=%b", k, da[1], ed); end
        end
    endtask

    task automatic test_stall_abort();
        int n = 0;
        logic seen = 1'b0;
        wr(1, MODE_BURST, 3, 2, 2);
        @(negedge clk);
        cfg_a.cfg_chan = 2'd1; cfg_a.cfg_mode = MODE_BLINK;
        cfg_a.cfg_period = 16'd4; cfg_a.cfg_high = 16'd1; cfg_a.cfg_valid = 1'b1;
        #1;
        total++; if (cfg_a.cfg_ready !== 1'b0) begin bad++; $display("FAIL stall_busy_ready got=%b exp=0", cfg_a.cfg_ready); end
        cfg_a.cfg_chan = 2'd0;
        #1;
        total++; if (cfg_a.cfg_ready !== 1'b1) begin bad++; $display("FAIL stall_other_ready got=%b exp=1", cfg_a.cfg_ready); end
        @(posedge clk);
        #1 cfg_a.cfg_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        total++; if (qa[0] !== 1'b1) begin bad++; $display("FAIL stall_other_q got=%b exp=1", qa[0]); end
        total++; if (ba[1] !== 1'b1) begin bad++; $display("FAIL stall_still_busy got=%b exp=1", ba[1]); end
        cfg_a.cfg_chan = 2'd1; cfg_a.cfg_mode = MODE_OFF; cfg_a.cfg_valid = 1'b1;
        #1;
        total++; if (cfg_a.cfg_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", cfg_a.cfg_ready); end
        @(posedge clk);
        #1 cfg_a.cfg_valid = 1'b0;
        @(negedge clk);
        total++; if (ba[1] !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", ba[1]); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen = seen | da[1];
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", seen); end
        total++; if (qa[1] !== 1'b0) begin bad++; $display("FAIL abort_q got=%b exp=0", qa[1]); end
        wr(1, MODE_BURST, 3, 2, 1);
        @(negedge clk);
        cfg_a.cfg_chan = 2'd1; cfg_a.cfg_mode = MODE_BLINK;
        cfg_a.cfg_period = 16'd4; cfg_a.cfg_high = 16'd1; cfg_a.cfg_valid = 1'b1;
        while (!cfg_a.cfg_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        total++; if (n !== 3) begin bad++; $display("FAIL stall_cycles got=%0d exp=3", n); end
        total++; if (da[1] !== 1'b1) begin bad++; $display("FAIL stall_release_done got=%b exp=1", da[1]); end
        @(posedge clk);
        #1 cfg_a.cfg_valid = 1'b0;
        wr(0, MODE_OFF, 0, 0, 0);
        wr(1, MODE_OFF, 0, 0, 0);
    endtask

    task automatic test_edges();
        logic any1, all1, anyb;
        wr(0, MODE_BLINK, 4, 0, 0);
        @(posedge clk);
        any1 = 1'b0;
        for (int k = 0; k < 8; k++) begin @(negedge clk); any1 = any1 | qa[0]; end
        total++; if (any1 !== 1'b0) begin bad++; $display("FAIL edge_high0 got=%b exp=0", any1); end
        wr(0, MODE_BLINK, 4, 5, 0);
        @(posedge clk);
        all1 = 1'b1;
        for (int k = 0; k < 8; k++) begin @(negedge clk); all1 = all1 & qa[0]; end
        total++; if (all1 !== 1'b1) begin bad++; $display("FAIL edge_high_ge_period got=%b exp=1", all1); end
        wr(0, MODE_BLINK, 0, 1, 0);
        @(posedge clk);
        any1 = 1'b0;
        for (int k = 0; k < 8; k++) begin @(negedge clk); any1 = any1 | qa[0]; end
        total++; if (any1 !== 1'b0) begin bad++; $display("FAIL edge_period0 got=%b exp=0", any1); end
        wr(2, MODE_BURST, 3, 2, 0);
        anyb = 1'b0; any1 = 1'b0;
        for (int k = 0; k < 8; k++) begin @(negedge clk); anyb = anyb | ba[2]; any1 = any1 | qa[2]; end
        total++; if (anyb !== 1'b0) begin bad++; $display("FAIL edge_count0_busy got=%b exp=0", anyb); end
        total++; if (any1 !== 1'b0) begin bad++; $display("FAIL edge_count0_q got=%b exp=0", any1); end
        wr(0, MODE_ON, 0, 0, 0);
        @(posedge clk); @(negedge clk);
        total++; if (qa !== 3'b001) begin bad++; $display("FAIL edge_on got=%b exp=001", qa); end
        wr(3, MODE_BURST, 3, 2, 5);
        anyb = 1'b0; all1 = 1'b1;
        for (int k = 0; k < 8; k++) begin @(negedge clk); anyb = anyb | (|ba); all1 = all1 & (qa == 3'b001); end
        total++; if (all1 !== 1'b1) begin bad++; $display("FAIL edge_bad_chan_q got=%b exp=1", all1); end
        total++; if (anyb !== 1'b0) begin bad++; $display("FAIL edge_bad_chan_busy got=%b exp=0", anyb); end
    endtask

    task automatic test_reset_mid();
        logic anyq;
        wr(0, MODE_BLINK, 4, 1, 0);
        wr(1, MODE_BURST, 3, 2, 5);
        @(negedge clk);
        total++; if (ba[1] !== 1'b1) begin bad++; $display("FAIL mid_pre_busy got=%b exp=1", ba[1]); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (qa !== 3'b000) begin bad++; $display("FAIL mid_rst_q got=%b exp=000", qa); end
        total++; if (ba !== 3'b000) begin bad++; $display("FAIL mid_rst_busy got=%b exp=000", ba); end
        total++; if (da !== 3'b000) begin bad++; $display("FAIL mid_rst_done got=%b exp=000", da); end
        total++; if (cfg_a.cfg_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", cfg_a.cfg_ready); end
        @(negedge clk);
        rst = 1'b0;
        anyq = 1'b0;
        for (int k = 0; k < 8; k++) begin @(negedge clk); anyq = anyq | (|qa) | (|ba); end
        total++; if (anyq !== 1'b0) begin bad++; $display("FAIL mid_after_release got=%b exp=0", anyq); end
    endtask

    task automatic test_prescale();
        int n = 0;
        logic prev, e;
        @(negedge clk);
        cfg_p.cfg_chan = 2'd0; cfg_p.cfg_mode = MODE_BLINK;
        cfg_p.cfg_period = 16'd2; cfg_p.cfg_high = 16'd1; cfg_p.cfg_count = 8'd0;
        cfg_p.cfg_valid = 1'b1;
        @(posedge clk);
        #1 cfg_p.cfg_valid = 1'b0;
        repeat (8) @(negedge clk);
        prev = qp[0];
        while (n < 20) begin
            @(negedge clk);
            if (!prev && qp[0]) break;
            prev = qp[0];
            n++;
        end
        total++; if (n >= 20) begin bad++; $display("FAIL ps_rise_timeout got=%0d exp<20", n); end
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            e = (i < 3) || (i >= 6 && i < 9);
            total++; if (qp[0] !== e) begin bad++; $display("FAIL ps_q i=%0d got=%b exp=%b", i, qp[0], e); end
        end
    endtask

    initial begin
        cfg_a.cfg_valid = 1'b0; cfg_a.cfg_chan = '0; cfg_a.cfg_mode = MODE_OFF;
        cfg_a.cfg_period = '0; cfg_a.cfg_high = '0; cfg_a.cfg_count = '0;
        cfg_p.cfg_valid = 1'b0; cfg_p.cfg_chan = '0; cfg_p.cfg_mode = MODE_OFF;
        cfg_p.cfg_period = '0; cfg_p.cfg_high = '0; cfg_p.cfg_count = '0;
        test_reset();
        test_blink();
        test_burst();
        test_stall_abort();
        test_edges();
        test_reset_mid();
        test_prescale();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
